// File: rtl/ss_scan_driver.sv
// ss_scan_driver: multiplexed seven-segment display driver for NUM_DIGITS
// common-anode digits.
//  - One digit is enabled at a time, and the driver advances to the next digit
//    every 2^PRESCALE_BITS cycles.
//  - Segments are blanked for BLANK_CYCLES cycles after each digit switch, so
//    the previous digit's glyph never ghosts onto the new digit.
//  - Brightness comes from a free-running PWM counter compared against
//    'brightness'.
//  - New values pass through a shadow register and reach the display register
//    only when the scan wraps to digit 0. A frame therefore never mixes old and
//    new values.
//  - Every output is registered. Each output is computed from the next-state
//    values, so the digit enables and the segments always change together.
//
// Optional feature (compile-time macro SS_SCAN_LZB_EN): leading-zero blanking.
// Digits above the highest nonzero digit show no segments. Their decimal point
// is still shown. Digit 0 is never blanked.
//
// Load handshake: 'load' is a single-cycle request with no ready. The shadow
// register captures digits_in/dp_in on every cycle where load=1, and a later
// load overwrites an earlier one. load_pending stays high until the wrap tick
// moves the shadow into the display register. A load on the wrap tick itself
// goes straight to the display and never raises load_pending.

module ss_scan_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int PRESCALE_BITS = 17,
  parameter int PWM_BITS      = 8,
  parameter int BLANK_CYCLES  = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   SegmentDrivers,
  output logic [7:0]              SevenSegment,
  output logic                    frame_done,
  output logic                    load_pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Scan / timing state
  logic [PRESCALE_BITS-1:0] presc;
  logic [IDX_W-1:0]         idx;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic [BLK_W-1:0]         blank_cnt;

  // Display and shadow registers
  logic [4*NUM_DIGITS-1:0]  disp;
  logic [NUM_DIGITS-1:0]    disp_dp;
  logic [4*NUM_DIGITS-1:0]  shadow;
  logic [NUM_DIGITS-1:0]    shadow_dp;

  // Next-state values
  logic                     tick;
  logic                     wrap_tick;
  logic [PRESCALE_BITS-1:0] presc_n;
  logic [IDX_W-1:0]         idx_n;
  logic [PWM_BITS-1:0]      pwm_n;
  logic [BLK_W-1:0]         blank_n;
  logic [4*NUM_DIGITS-1:0]  disp_n;
  logic [NUM_DIGITS-1:0]    disp_dp_n;
  logic [4*NUM_DIGITS-1:0]  shadow_n;
  logic [NUM_DIGITS-1:0]    shadow_dp_n;
  logic                     pending_n;
  logic [3:0]               nibble;
  logic                     dp_sel;
  logic [6:0]               glyph;
  logic [7:0]               seg_n;
`ifdef SS_SCAN_LZB_EN
  logic [IDX_W-1:0]         top_nz;
`endif

  // Active-high glyph, bit0 = a .. bit6 = g. With hex_mode=0, values 10..15
  // decode to all segments off.
  function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = hex ? 7'h77 : 7'h00;
      4'hB: g = hex ? 7'h7C : 7'h00;
      4'hC: g = hex ? 7'h39 : 7'h00;
      4'hD: g = hex ? 7'h5E : 7'h00;
      4'hE: g = hex ? 7'h79 : 7'h00;
      default: g = hex ? 7'h71 : 7'h00;
    endcase
    return g;
  endfunction

  // Next-state for scan timing, shadow/display registers and segment outputs
  always_comb begin
    presc_n     = presc + 1'b1;
    tick        = &presc;
    wrap_tick   = tick && (idx == LAST_IDX);
    idx_n       = idx;
    if (tick) idx_n = wrap_tick ? '0 : idx + 1'b1;
    pwm_n       = pwm_cnt + 1'b1;
    blank_n     = '0;
    if (tick)                blank_n = BLK_W'(BLANK_CYCLES);
    else if (blank_cnt != 0) blank_n = blank_cnt - 1'b1;

    shadow_n    = load ? digits_in : shadow;
    shadow_dp_n = load ? dp_in : shadow_dp;
    disp_n      = wrap_tick ? shadow_n : disp;
    disp_dp_n   = wrap_tick ? shadow_dp_n : disp_dp;
    pending_n   = wrap_tick ? 1'b0 : (load_pending | load);

    nibble      = disp_n[{idx_n, 2'b00} +: 4];
    dp_sel      = disp_dp_n[idx_n];
    glyph       = decode(nibble, hex_mode);
`ifdef SS_SCAN_LZB_EN
    top_nz      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (disp_n[4*k +: 4] != 4'h0) top_nz = IDX_W'(k);
    end
    if (idx_n > top_nz) glyph = 7'h00;
`endif

    seg_n       = 8'hFF;
    if ((pwm_n < brightness) && (blank_n == '0)) seg_n = ~{dp_sel, glyph};
  end

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc          <= '0;
      idx            <= '0;
      pwm_cnt        <= '0;
      blank_cnt      <= '0;
      disp           <= '0;
      disp_dp        <= '0;
      shadow         <= '0;
      shadow_dp      <= '0;
      load_pending   <= 1'b0;
      SegmentDrivers <= '1;
      SevenSegment   <= 8'hFF;
      frame_done     <= 1'b0;
    end else begin
      presc          <= presc_n;
      idx            <= idx_n;
      pwm_cnt        <= pwm_n;
      blank_cnt      <= blank_n;
      disp           <= disp_n;
      disp_dp        <= disp_dp_n;
      shadow         <= shadow_n;
      shadow_dp      <= shadow_dp_n;
      load_pending   <= pending_n;
      SegmentDrivers <= ~(NUM_DIGITS'(1) << idx_n);
      SevenSegment   <= seg_n;
      frame_done     <= wrap_tick;
    end
  end

endmodule
